// File: rtl/perf_pkg.sv
// perf_pkg: state encodings, FSM enum and per-run result bundle for conv_perf_monitor
package perf_pkg;
    localparam logic [1:0] RUN_IDLE = 2'd0;
    localparam logic [1:0] RUN_RUN  = 2'd1;
    localparam logic [1:0] RUN_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = RUN_IDLE,
        RUN  = RUN_RUN,
        DONE = RUN_DONE
    } perf_state_t;

    // Result widths for the default-parameter monitor
    localparam int RES_CNT_W = 48;
    localparam int RES_EVT_W = 32;
    localparam int RES_LANES = 5;

    typedef struct packed {
        logic [RES_CNT_W-1:0]                run_cycles;
        logic [RES_CNT_W-1:0]                first_out_latency;
        logic                                first_out_seen;
        logic [RES_EVT_W-1:0]                out_count;
        logic [RES_LANES-1:0][RES_EVT_W-1:0] stall;
        logic                                saturated;
        logic                                timeout;
    } perf_result_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: unsigned up-counter that sticks at all-ones instead of wrapping
//   clk, arst_n_in : clock, async active-low reset
//   clr            : synchronous zero (wins over inc)
//   inc            : count one event
//   value, at_max  : current count, count is all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);
    assign at_max = &value;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc && !at_max)
            value <= value + 1'b1;
    end
endmodule

// File: rtl/conv_perf_monitor.sv
// conv_perf_monitor: passive run monitor measuring run length, first-output latency,
// output count, per-lane stalls, saturation and timeout of an accelerator run.
//   inputs : clk, arst_n_in, start, running, lane_valid/lane_ready[NB_LANES],
//            output_valid, clear
//   outputs: state_o, total_cycles, run_cycles, first_out_latency, first_out_seen,
//            out_count, stall_cycles (lane i at [i*EVT_WIDTH +: EVT_WIDTH]),
//            saturated, timeout, done_o
module conv_perf_monitor
    import perf_pkg::*;
#(
    parameter int          NB_LANES       = 5,
    parameter int          CNT_WIDTH      = 48,
    parameter int          EVT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    input  logic                          running,
    input  logic [NB_LANES-1:0]           lane_valid,
    input  logic [NB_LANES-1:0]           lane_ready,
    input  logic                          output_valid,
    input  logic                          clear,
    output logic [1:0]                    state_o,
    output logic [CNT_WIDTH-1:0]          total_cycles,
    output logic [CNT_WIDTH-1:0]          run_cycles,
    output logic [CNT_WIDTH-1:0]          first_out_latency,
    output logic                          first_out_seen,
    output logic [EVT_WIDTH-1:0]          out_count,
    output logic [NB_LANES*EVT_WIDTH-1:0] stall_cycles,
    output logic                          saturated,
    output logic                          timeout,
    output logic                          done_o
);
    perf_state_t          state, state_d;
    logic                 in_run, go, clr, normal_exit, to_hit;
    logic                 running_seen, sat_sticky, run_max, out_max, any_max;
    logic [NB_LANES-1:0]  stall_max;
    logic [CNT_WIDTH-1:0] run_next;

    assign in_run      = state == RUN;
    // start is only honoured outside RUN, and clear overrides it
    assign go          = start && !clear && !in_run;
    assign clr         = clear || go;
    assign run_next    = run_max ? run_cycles : run_cycles + 1'b1;
    assign normal_exit = !running && running_seen;
    assign to_hit      = TIMEOUT_CYCLES != 0 && run_next == CNT_WIDTH'(TIMEOUT_CYCLES);
    assign any_max     = run_max || out_max || |stall_max;
    // counters hold at all-ones, so the live flag covers the cycle they get there
    assign saturated   = sat_sticky || any_max;
    assign state_o     = state;

    always_comb begin
        state_d = state;
        if (clear)
            state_d = IDLE;
        else if (go)
            state_d = RUN;
        else if (in_run && (normal_exit || to_hit))
            state_d = DONE;
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            total_cycles      <= '0;
            running_seen      <= 1'b0;
            first_out_latency <= '0;
            first_out_seen    <= 1'b0;
            sat_sticky        <= 1'b0;
            timeout           <= 1'b0;
            done_o            <= 1'b0;
        end else begin
            total_cycles <= total_cycles + 1'b1;
            done_o       <= state_d == DONE && state != DONE;
            if (clr) begin
                running_seen      <= 1'b0;
                first_out_latency <= '0;
                first_out_seen    <= 1'b0;
                sat_sticky        <= 1'b0;
                timeout           <= 1'b0;
            end else begin
                sat_sticky <= sat_sticky || any_max;
                if (in_run) begin
                    if (running)
                        running_seen <= 1'b1;
                    if (output_valid && !first_out_seen) begin
                        first_out_latency <= run_next;
                        first_out_seen    <= 1'b1;
                    end
                    // a normal exit in the timeout cycle is not a timeout
                    if (state_d == DONE)
                        timeout <= !normal_exit;
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_run (
        .clk(clk), .arst_n_in(arst_n_in), .clr(clr), .inc(in_run),
        .value(run_cycles), .at_max(run_max)
    );

    sat_counter #(.WIDTH(EVT_WIDTH)) u_out (
        .clk(clk), .arst_n_in(arst_n_in), .clr(clr), .inc(in_run && output_valid),
        .value(out_count), .at_max(out_max)
    );

    for (genvar i = 0; i < NB_LANES; i++) begin : g_stall
        sat_counter #(.WIDTH(EVT_WIDTH)) u_stall (
            .clk(clk), .arst_n_in(arst_n_in), .clr(clr),
            .inc(in_run && lane_valid[i] && !lane_ready[i]),
            .value(stall_cycles[i*EVT_WIDTH +: EVT_WIDTH]), .at_max(stall_max[i])
        );
    end
endmodule

// File: tb/tb_conv_perf_monitor.sv
// tb_conv_perf_monitor: directed bench for conv_perf_monitor; a default instance and a
// small instance (EVT_WIDTH=4, TIMEOUT_CYCLES=50) share one stimulus stream.
module tb_conv_perf_monitor;
    import perf_pkg::*;

    localparam int NL  = 5;
    localparam int CW  = 48;
    localparam int EW  = 32;
    localparam int SEW = 4;

    logic          clk = 1'b0;
    logic          arst_n_in = 1'b1;
    logic          start = 1'b0;
    logic          running = 1'b0;
    logic          output_valid = 1'b0;
    logic          clear = 1'b0;
    logic [NL-1:0] lane_valid = '0;
    logic [NL-1:0] lane_ready = '1;

    logic [1:0]       state_o;
    logic [CW-1:0]    total_cycles, run_cycles, first_out_latency;
    logic             first_out_seen, saturated, timeout, done_o;
    logic [EW-1:0]    out_count;
    logic [NL*EW-1:0] stall_cycles;

    logic [1:0]        s_state;
    logic [CW-1:0]     s_total, s_run, s_lat;
    logic              s_seen, s_sat, s_timeout, s_done;
    logic [SEW-1:0]    s_out;
    logic [NL*SEW-1:0] s_stall;

    int     checks = 0;
    int     fails = 0;
    longint ncyc = 0;

    conv_perf_monitor dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running),
        .lane_valid(lane_valid), .lane_ready(lane_ready), .output_valid(output_valid),
        .clear(clear), .state_o(state_o), .total_cycles(total_cycles),
        .run_cycles(run_cycles), .first_out_latency(first_out_latency),
        .first_out_seen(first_out_seen), .out_count(out_count),
        .stall_cycles(stall_cycles), .saturated(saturated), .timeout(timeout),
        .done_o(done_o)
    );

    conv_perf_monitor #(.EVT_WIDTH(SEW), .TIMEOUT_CYCLES(50)) dut_s (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running),
        .lane_valid(lane_valid), .lane_ready(lane_ready), .output_valid(output_valid),
        .clear(clear), .state_o(s_state), .total_cycles(s_total),
        .run_cycles(s_run), .first_out_latency(s_lat),
        .first_out_seen(s_seen), .out_count(s_out),
        .stall_cycles(s_stall), .saturated(s_sat), .timeout(s_timeout),
        .done_o(s_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    function automatic perf_result_t mk(longint rc, longint lat, logic seen, longint cnt,
                                        logic [NL-1:0][EW-1:0] st, logic sat, logic to);
        perf_result_t r;
        r.run_cycles        = CW'(rc);
        r.first_out_latency = CW'(lat);
        r.first_out_seen    = seen;
        r.out_count         = EW'(cnt);
        r.stall             = st;
        r.saturated         = sat;
        r.timeout           = to;
        return r;
    endfunction

    task automatic check_res(input string tag, input perf_result_t e);
        check({tag, ".run"}, 64'(run_cycles), 64'(e.run_cycles));
        check({tag, ".lat"}, 64'(first_out_latency), 64'(e.first_out_latency));
        check({tag, ".seen"}, 64'(first_out_seen), 64'(e.first_out_seen));
        check({tag, ".cnt"}, 64'(out_count), 64'(e.out_count));
        for (int i = 0; i < NL; i++)
            check($sformatf("%s.stall%0d", tag, i), 64'(stall_cycles[i*EW +: EW]), 64'(e.stall[i]));
        check({tag, ".sat"}, 64'(saturated), 64'(e.saturated));
        check({tag, ".to"}, 64'(timeout), 64'(e.timeout));
    endtask

    initial begin
        // reset
        #1 arst_n_in = 1'b0;
        #2;
        check("rst_state", 64'(state_o), 0);
        check("rst_total", 64'(total_cycles), 0);
        check("rst_done", 64'(done_o), 0);
        check_res("rst", mk(0, 0, 0, 0, '0, 0, 0));
        #9 arst_n_in = 1'b1;
        ncyc = 0;
        repeat (3) tick();
        check("idle_total", 64'(total_cycles), 64'(ncyc));
        check("idle_state", 64'(state_o), 0);
        check("idle_run", 64'(run_cycles), 0);

        // nominal run with stall accounting
        start = 1'b1;
        tick();
        start = 1'b0;
        check("nom_enter_state", 64'(state_o), 1);
        check("nom_enter_run", 64'(run_cycles), 0);
        for (int c = 1; c <= 101; c++) begin
            running       = c <= 100;
            output_valid  = c >= 10 && c <= 19;
            lane_valid[0] = 1'b1;
            lane_valid[2] = c >= 20 && c <= 26;
            lane_ready[2] = !(c >= 20 && c <= 26);
            lane_valid[4] = c >= 30 && c <= 32;
            lane_ready[4] = !(c >= 30 && c <= 32);
            tick();
            if (c == 50) begin
                check("nom_mid_state", 64'(state_o), 1);
                check("nom_mid_run", 64'(run_cycles), 50);
                check("nom_mid_done", 64'(done_o), 0);
            end
        end
        running = 1'b0;
        output_valid = 1'b0;
        lane_valid = '0;
        lane_ready = '1;
        check("nom_state", 64'(state_o), 2);
        check("nom_done", 64'(done_o), 1);
        check_res("nom", mk(101, 10, 1, 10, {32'd3, 32'd0, 32'd7, 32'd0, 32'd0}, 0, 0));
        check("nom_total", 64'(total_cycles), 64'(ncyc));

        // back-to-back: start in the first DONE cycle; stall here is outside RUN
        start = 1'b1;
        lane_valid[3] = 1'b1;
        lane_ready[3] = 1'b0;
        tick();
        start = 1'b0;
        lane_valid = '0;
        lane_ready = '1;
        check("b2b_state", 64'(state_o), 1);
        check("b2b_done", 64'(done_o), 0);
        check_res("b2b_enter", mk(0, 0, 0, 0, '0, 0, 0));
        for (int c = 1; c <= 6; c++) begin
            running      = c <= 5;
            output_valid = c == 3;
            tick();
        end
        running = 1'b0;
        output_valid = 1'b0;
        check("b2b_end_state", 64'(state_o), 2);
        check("b2b_end_done", 64'(done_o), 1);
        check_res("b2b_end", mk(6, 3, 1, 1, '0, 0, 0));
        // DONE holds; stall outside RUN is ignored
        lane_valid[1] = 1'b1;
        lane_ready[1] = 1'b0;
        tick();
        lane_valid = '0;
        lane_ready = '1;
        check("hold_state", 64'(state_o), 2);
        check("hold_done", 64'(done_o), 0);
        check_res("hold", mk(6, 3, 1, 1, '0, 0, 0));

        // clear beats start
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("prio_state", 64'(state_o), 0);
        check("prio_s_state", 64'(s_state), 0);
        check("prio_done", 64'(done_o), 0);
        check_res("prio", mk(0, 0, 0, 0, '0, 0, 0));

        // saturation on the 4-bit instance
        start = 1'b1;
        tick();
        start = 1'b0;
        running = 1'b1;
        output_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 14) begin
                check("sat14_out", 64'(s_out), 14);
                check("sat14_flag", 64'(s_sat), 0);
            end
            if (c == 15) begin
                check("sat15_out", 64'(s_out), 15);
                check("sat15_flag", 64'(s_sat), 1);
            end
        end
        running = 1'b0;
        output_valid = 1'b0;
        tick();
        check("sat_s_state", 64'(s_state), 2);
        check("sat_s_done", 64'(s_done), 1);
        check("sat_s_out", 64'(s_out), 15);
        check("sat_s_flag", 64'(s_sat), 1);
        check("sat_s_run", 64'(s_run), 21);
        check("sat_s_lat", 64'(s_lat), 1);
        check("sat_s_to", 64'(s_timeout), 0);
        check_res("sat_wide", mk(21, 1, 1, 20, '0, 0, 0));
        tick();
        check("sat_s_hold", 64'(s_sat), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("sat_s_clr_flag", 64'(s_sat), 0);
        check("sat_s_clr_out", 64'(s_out), 0);

        // timeout on the small instance; the wide one keeps running
        start = 1'b1;
        tick();
        start = 1'b0;
        running = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 49) begin
                check("to49_state", 64'(s_state), 1);
                check("to49_run", 64'(s_run), 49);
            end
        end
        check("to_s_state", 64'(s_state), 2);
        check("to_s_run", 64'(s_run), 50);
        check("to_s_flag", 64'(s_timeout), 1);
        check("to_s_done", 64'(s_done), 1);
        check("to_state", 64'(state_o), 1);
        check("to_run", 64'(run_cycles), 50);
        // second run exits normally in the timeout cycle; start is ignored in RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to2_s_enter_flag", 64'(s_timeout), 0);
        check("to2_s_enter_state", 64'(s_state), 1);
        check("to2_ignore_state", 64'(state_o), 1);
        check("to2_ignore_run", 64'(run_cycles), 51);
        for (int c = 1; c <= 50; c++) begin
            running = c <= 49;
            tick();
        end
        running = 1'b0;
        check("to2_s_state", 64'(s_state), 2);
        check("to2_s_run", 64'(s_run), 50);
        check("to2_s_flag", 64'(s_timeout), 0);
        check("to2_s_done", 64'(s_done), 1);
        check("to2_state", 64'(state_o), 2);
        check("to2_run", 64'(run_cycles), 101);
        check("to2_flag", 64'(timeout), 0);

        // asynchronous reset mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        running = 1'b1;
        output_valid = 1'b1;
        repeat (5) tick();
        check("mr_run", 64'(run_cycles), 5);
        arst_n_in = 1'b0;
        #1;
        check("mr_state", 64'(state_o), 0);
        check("mr_total", 64'(total_cycles), 0);
        check("mr_done", 64'(done_o), 0);
        check("mr_s_state", 64'(s_state), 0);
        check_res("mr", mk(0, 0, 0, 0, '0, 0, 0));
        repeat (2) tick();
        check("mr_hold_done", 64'(done_o), 0);
        check("mr_hold_state", 64'(state_o), 0);
        running = 1'b0;
        output_valid = 1'b0;
        arst_n_in = 1'b1;
        ncyc = 0;
        tick();
        check("post_rst_total", 64'(total_cycles), 64'(ncyc));
        check("post_rst_state", 64'(state_o), 0);
        check("post_rst_done", 64'(done_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
